// File: rtl/scpad_frontend_queue_if.sv
// Handshake bundle between a vector-core port, the frontend queue and the scratchpad body.
// The frontend takes the slave view; the core/body side (or a bench) takes the master view.
interface scpad_frontend_queue_if #(
  parameter int REQ_W = 64,
  parameter int RES_W = 64
);
  logic             vec_req_valid;
  logic             vec_req_ready;
  logic [REQ_W-1:0] vec_req_data;
  logic             body_req_valid;
  logic             body_req_ready;
  logic [REQ_W-1:0] body_req_data;
  logic             body_res_valid;
  logic [RES_W-1:0] body_res_data;
  logic             vec_res_valid;
  logic             vec_res_ready;
  logic [RES_W-1:0] vec_res_data;

  modport slave (
    input  vec_req_valid, vec_req_data, body_req_ready,
    input  body_res_valid, body_res_data, vec_res_ready,
    output vec_req_ready, body_req_valid, body_req_data,
    output vec_res_valid, vec_res_data
  );

  modport master (
    output vec_req_valid, vec_req_data, body_req_ready,
    output body_res_valid, body_res_data, vec_res_ready,
    input  vec_req_ready, body_req_valid, body_req_data,
    input  vec_res_valid, vec_res_data
  );
endinterface

// File: rtl/scpad_frontend_queue.sv
// Scratchpad frontend for one vector-core port: request FIFO toward the body, response FIFO
// toward the core, with response-FIFO credits gating issue so body responses are never dropped.
module scpad_frontend_queue #(
  parameter int IDX       = 0,
  parameter int REQ_W     = 64,
  parameter int RES_W     = 64,
  parameter int REQ_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  scpad_frontend_queue_if.slave          bus,
  output logic                           fe_vec_stall,
  output logic [$clog2(REQ_DEPTH+1)-1:0] req_count,
  output logic [$clog2(RES_DEPTH+1)-1:0] outstanding,
  output logic                           spurious_res
);
  localparam int RQ_PW = $clog2(REQ_DEPTH);
  localparam int RQ_CW = $clog2(REQ_DEPTH + 1);
  localparam int RS_PW = $clog2(RES_DEPTH);
  localparam int RS_CW = $clog2(RES_DEPTH + 1);
  localparam logic [RQ_CW-1:0] RQ_FULL = RQ_CW'(REQ_DEPTH);
  localparam logic [RS_CW-1:0] RS_FULL = RS_CW'(RES_DEPTH);
  localparam bit CFG_OK = (IDX >= 0) && (REQ_DEPTH >= 2) && (RES_DEPTH >= 2) &&
                          ((REQ_DEPTH & (REQ_DEPTH - 1)) == 0) &&
                          ((RES_DEPTH & (RES_DEPTH - 1)) == 0);

  logic [REQ_W-1:0] req_mem [REQ_DEPTH];
  logic [RQ_PW-1:0] req_wr_ptr, req_rd_ptr;
  logic [RQ_CW-1:0] req_cnt;
  logic [RES_W-1:0] res_mem [RES_DEPTH];
  logic [RS_PW-1:0] res_wr_ptr, res_rd_ptr;
  logic [RS_CW-1:0] res_cnt;
  logic [RS_CW-1:0] outst_cnt;
  logic [RS_CW-1:0] inflight;
  logic             spurious_q;

  logic req_push, req_issue, req_nonempty;
  logic res_capture, res_pop, res_nonempty;

  // Ready looks only at the registered count, so a full FIFO refuses even with a pop pending.
  assign bus.vec_req_ready  = (req_cnt != RQ_FULL);
  assign fe_vec_stall       = (req_cnt == RQ_FULL);
  assign req_nonempty       = (req_cnt != '0);
  assign bus.body_req_valid = req_nonempty & (outst_cnt != RS_FULL) & ~flush;
  assign bus.body_req_data  = req_nonempty ? req_mem[req_rd_ptr] : '0;
  assign req_push           = bus.vec_req_valid & bus.vec_req_ready & ~flush;
  assign req_issue          = bus.body_req_valid & bus.body_req_ready;

  assign res_nonempty       = (res_cnt != '0);
  assign bus.vec_res_valid  = res_nonempty;
  assign bus.vec_res_data   = res_nonempty ? res_mem[res_rd_ptr] : '0;
  assign res_capture        = bus.body_res_valid & (inflight != '0);
  assign res_pop            = res_nonempty & bus.vec_res_ready;

  assign req_count          = req_cnt;
  assign outstanding        = outst_cnt;
  assign spurious_res       = spurious_q;

  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr_ptr] <= bus.vec_req_data;
    if (res_capture) res_mem[res_wr_ptr] <= bus.body_res_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_cnt    <= '0;
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_cnt    <= '0;
      outst_cnt  <= '0;
      inflight   <= '0;
      spurious_q <= 1'b0;
    end else begin
      // Flush blocks both push and issue, so clearing the request side is all it needs.
      if (flush) begin
        req_wr_ptr <= '0;
        req_rd_ptr <= '0;
        req_cnt    <= '0;
      end else begin
        if (req_push)  req_wr_ptr <= req_wr_ptr + RQ_PW'(1);
        if (req_issue) req_rd_ptr <= req_rd_ptr + RQ_PW'(1);
        case ({req_push, req_issue})
          2'b10:   req_cnt <= req_cnt + RQ_CW'(1);
          2'b01:   req_cnt <= req_cnt - RQ_CW'(1);
          default: req_cnt <= req_cnt;
        endcase
      end

      if (res_capture) res_wr_ptr <= res_wr_ptr + RS_PW'(1);
      if (res_pop)     res_rd_ptr <= res_rd_ptr + RS_PW'(1);
      case ({res_capture, res_pop})
        2'b10:   res_cnt <= res_cnt + RS_CW'(1);
        2'b01:   res_cnt <= res_cnt - RS_CW'(1);
        default: res_cnt <= res_cnt;
      endcase

      case ({req_issue, res_pop})
        2'b10:   outst_cnt <= outst_cnt + RS_CW'(1);
        2'b01:   outst_cnt <= outst_cnt - RS_CW'(1);
        default: outst_cnt <= outst_cnt;
      endcase

      case ({req_issue, res_capture})
        2'b10:   inflight <= inflight + RS_CW'(1);
        2'b01:   inflight <= inflight - RS_CW'(1);
        default: inflight <= inflight;
      endcase

      if (bus.body_res_valid && (inflight == '0)) spurious_q <= 1'b1;
    end
  end

  cfg_check: assert property (@(posedge clk) CFG_OK);
endmodule
